msk_aes_col_buffer: RTL and testbench

Masked column-serial state buffer that sits directly downstream of the masked MixColumns stage in the 32-bit masked AES datapath. It accepts one masked column per handshake, selects either the MixColumns result or the raw column (last round), adds the masked round-key column sharewise, stores four columns, then drains them in order to the next round's SubBytes/ShiftRows path. All processing is sharewise XOR and registering. No randomness is consumed, and shares are never combined.

---
 rtl/msk_aes_col_buffer.sv | 89 ++++++++
 tb/tb_msk_aes_col_buffer.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/msk_aes_col_buffer.sv
// Masked column buffer after MixColumns: sharewise round-key add, gathers 4 columns, drains them in order.
// Latency: column 0 is presented the cycle after the 4th acceptance; output data is registered.
// Backpressure: in_ready is low while draining; out_ready low freezes the head column and out_last.
module msk_aes_col_buffer #(
    parameter int d = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            in_mc_bypass,
    input  logic [32*d-1:0] sh_col_mc,
    input  logic [32*d-1:0] sh_col_raw,
    input  logic [32*d-1:0] sh_rkey_col,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [32*d-1:0] sh_col_out,
    output logic            out_last
);

    localparam int W = 32 * d;

    typedef enum logic {
        LOAD  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t         state_q;
    state_t         state_d;
    logic [1:0]     col_cnt_q;
    logic [1:0]     col_cnt_d;
    logic [W-1:0]   col_q [4];

    logic           in_fire;
    logic           out_fire;
    logic           shift_en;
    logic [W-1:0]   ark_col;
    logic [W-1:0]   tail_col;

    // Sharewise ARK: each share is XORed with the matching key share, shares never meet.
    assign ark_col = (in_mc_bypass ? sh_col_raw : sh_col_mc) ^ sh_rkey_col;

    always_comb begin
        state_d   = state_q;
        col_cnt_d = col_cnt_q;
        in_ready  = (state_q == LOAD) & ~rst;
        out_valid = (state_q == DRAIN) & ~rst;
        in_fire   = in_valid & in_ready;
        out_fire  = out_valid & out_ready;
        shift_en  = in_fire | out_fire;
        tail_col  = in_fire ? ark_col : '0;

        if (in_fire) begin
            col_cnt_d = col_cnt_q + 2'd1;
            if (col_cnt_q == 2'd3) begin
                state_d = DRAIN;
            end
        end else if (out_fire) begin
            col_cnt_d = col_cnt_q + 2'd1;
            if (col_cnt_q == 2'd3) begin
                state_d = LOAD;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= LOAD;
            col_cnt_q <= 2'd0;
            for (int i = 0; i < 4; i++) begin
                col_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            col_cnt_q <= col_cnt_d;
            // Fill shifts toward the head so column 0 ends up at entry 0; drain zero-fills the tail.
            if (shift_en) begin
                for (int i = 0; i < 3; i++) begin
                    col_q[i] <= col_q[i+1];
                end
                col_q[3] <= tail_col;
            end
        end
    end

    assign sh_col_out = rst ? '0 : col_q[0];
    assign out_last   = out_valid & (col_cnt_q == 2'd3);

endmodule

// File: tb/tb_msk_aes_col_buffer.sv
// Scoreboard bench for msk_aes_col_buffer with d=2: directed columns, masked inputs, unmasked output checks.
module tb_msk_aes_col_buffer;

    localparam int D = 2;
    localparam int W = 32 * D;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic         in_mc_bypass;
    logic [W-1:0] sh_col_mc;
    logic [W-1:0] sh_col_raw;
    logic [W-1:0] sh_rkey_col;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sh_col_out;
    logic         out_last;

    typedef struct {
        logic [31:0] u;
        logic        last;
        logic        s1z;
    } exp_t;

    exp_t sbq[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   grp_idx = 0;
    int   cyc = 0;
    int   lowcnt = 0;
    int   last_acc_cyc = 0;
    int   acc_cyc[3];
    int   acc_low[3];
    logic [W-1:0] snap;

    msk_aes_col_buffer #(.d(D)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_mc_bypass (in_mc_bypass),
        .sh_col_mc    (sh_col_mc),
        .sh_col_raw   (sh_col_raw),
        .sh_rkey_col  (sh_rkey_col),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .sh_col_out   (sh_col_out),
        .out_last     (out_last)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    // Row r byte lives at u[8r +: 8].
    function automatic logic [31:0] mkcol(input logic [7:0] b0, b1, b2, b3);
        return {b3, b2, b1, b0};
    endfunction

    function automatic logic [W-1:0] msk(input logic [31:0] u, input logic [31:0] m);
        logic [W-1:0] s;
        s = '0;
        for (int r = 0; r < 4; r++) begin
            s[16*r +: 8]   = u[8*r +: 8] ^ m[8*r +: 8];
            s[16*r+8 +: 8] = m[8*r +: 8];
        end
        return s;
    endfunction

    function automatic logic [31:0] unmask(input logic [W-1:0] s);
        logic [31:0] u;
        for (int r = 0; r < 4; r++) u[8*r +: 8] = s[16*r +: 8] ^ s[16*r+8 +: 8];
        return u;
    endfunction

    function automatic logic [31:0] share1(input logic [W-1:0] s);
        logic [31:0] u;
        for (int r = 0; r < 4; r++) u[8*r +: 8] = s[16*r+8 +: 8];
        return u;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string nm);
        n_chk++;
        n_fail++;
        $display("FAIL %s: timed out (t=%0t)", nm, $time);
    endtask

    // Presents one column and returns just after the accepting clock edge; in_valid stays high.
    task automatic send(input logic byp, input logic [31:0] mc_u, input logic [31:0] raw_u,
                        input logic [31:0] key_u, input logic zero_masks, input logic [31:0] exp_u);
        int   n;
        exp_t e;
        @(negedge clk);
        in_mc_bypass = byp;
        sh_col_mc    = msk(mc_u,  zero_masks ? 32'h0 : $urandom);
        sh_col_raw   = msk(raw_u, zero_masks ? 32'h0 : $urandom);
        sh_rkey_col  = msk(key_u, zero_masks ? 32'h0 : $urandom);
        in_valid     = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            timeout_fail("in_ready_wait");
            return;
        end
        chk("out_valid_in_load", {63'd0, out_valid}, 64'd0);
        last_acc_cyc = cyc;
        e.u    = exp_u;
        e.last = (grp_idx == 3);
        e.s1z  = zero_masks;
        sbq.push_back(e);
        grp_idx = (grp_idx + 1) % 4;
        @(posedge clk);
    endtask

    task automatic idle_in();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (n < 60) begin
            @(negedge clk);
            #2;
            if (sbq.size() == 0 && in_ready) break;
            n++;
        end
        if (n >= 60) timeout_fail("drain_wait");
    endtask

    // Monitor: pops one expectation per output handshake.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (!rst && !in_ready) lowcnt++;
            if (!rst && out_valid && out_ready) begin
                if (sbq.size() == 0) begin
                    timeout_fail("unexpected_output");
                end else begin
                    e = sbq.pop_front();
                    chk("col_data", {32'd0, unmask(sh_col_out)}, {32'd0, e.u});
                    chk("col_last", {63'd0, out_last}, {63'd0, e.last});
                    if (e.s1z) chk("share1_zero", {32'd0, share1(sh_col_out)}, 64'd0);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_mc_bypass = 1'b0; out_ready = 1'b1;
        sh_col_mc = '0; sh_col_raw = '0; sh_rkey_col = '0;
        @(negedge clk);
        #1;
        chk("rst_in_ready",   {63'd0, in_ready},  64'd0);
        chk("rst_out_valid",  {63'd0, out_valid}, 64'd0);
        chk("rst_out_last",   {63'd0, out_last},  64'd0);
        chk("rst_sh_col_out", sh_col_out,         64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready",  {63'd0, in_ready},  64'd1);
        chk("post_rst_out_valid", {63'd0, out_valid}, 64'd0);

        // FIPS-197 MixColumns column, zero key.
        for (int i = 0; i < 4; i++)
            send(1'b0, mkcol(8'h8e, 8'h4d, 8'ha1, 8'hbc), $urandom, 32'h0, 1'b0,
                 mkcol(8'h8e, 8'h4d, 8'ha1, 8'hbc));
        #1;
        chk("first_out_latency", {63'd0, out_valid}, 64'd1);
        idle_in();
        wait_idle();

        // Bypass path with a key; MixColumns input is garbage.
        for (int i = 0; i < 4; i++)
            send(1'b1, $urandom, mkcol(8'hdb, 8'h13, 8'h53, 8'h45), mkcol(8'h01, 8'h02, 8'h03, 8'h04),
                 1'b0, mkcol(8'hda, 8'h11, 8'h50, 8'h41));
        idle_in();
        wait_idle();

        // MixColumns path with a key, all share1 inputs zero.
        for (int i = 0; i < 4; i++)
            send(1'b0, mkcol(8'h8e, 8'h4d, 8'ha1, 8'hbc), 32'h0, mkcol(8'h01, 8'h02, 8'h03, 8'h04),
                 1'b1, mkcol(8'h8f, 8'h4f, 8'ha2, 8'hb8));
        idle_in();
        wait_idle();

        // Backpressure on column 1.
        send(1'b1, 32'h0, 32'ha0a1a2a3, 32'h0, 1'b0, 32'ha0a1a2a3);
        send(1'b1, 32'h0, 32'hb0b1b2b3, 32'h0, 1'b0, 32'hb0b1b2b3);
        send(1'b1, 32'h0, 32'hc0c1c2c3, 32'h0, 1'b0, 32'hc0c1c2c3);
        send(1'b1, 32'h0, 32'hd0d1d2d3, 32'h0, 1'b0, 32'hd0d1d2d3);
        idle_in();
        @(negedge clk);
        out_ready = 1'b0;
        #1;
        snap = sh_col_out;
        chk("bp_col1_value", {32'd0, unmask(snap)}, 64'h00000000b0b1b2b3);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            #1;
            chk("bp_stable",    sh_col_out,          snap);
            chk("bp_in_ready",  {63'd0, in_ready},  64'd0);
            chk("bp_out_valid", {63'd0, out_valid}, 64'd1);
        end
        @(negedge clk);
        out_ready = 1'b1;
        wait_idle();

        // Reset mid-fill: the two partial columns must never appear.
        send(1'b1, 32'h0, 32'hdeadbeef, 32'h0, 1'b0, 32'hdeadbeef);
        send(1'b1, 32'h0, 32'hfeedface, 32'h0, 1'b0, 32'hfeedface);
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        sbq.delete();
        grp_idx = 0;
        #1;
        chk("midrst_in_ready",  {63'd0, in_ready},  64'd0);
        chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("after_rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("after_rst_sh_col_out", sh_col_out, 64'd0);
        for (int i = 0; i < 4; i++)
            send(1'b1, 32'h0, 32'h11111111 * (i + 1), 32'h0, 1'b0, 32'h11111111 * (i + 1));
        idle_in();
        wait_idle();

        // Back-to-back: three full states with in_valid and out_ready held high.
        for (int g = 0; g < 3; g++) begin
            for (int c = 0; c < 4; c++) begin
                send(1'b1, 32'h0, {8'(g), 8'(c), 8'h5a, 8'(g * 4 + c)}, 32'h0, 1'b0,
                     {8'(g), 8'(c), 8'h5a, 8'(g * 4 + c)});
                if (c == 0) begin
                    acc_cyc[g] = last_acc_cyc;
                    acc_low[g] = lowcnt;
                end
            end
        end
        idle_in();
        wait_idle();
        chk("b2b_period_0", 64'(acc_cyc[1] - acc_cyc[0]), 64'd8);
        chk("b2b_period_1", 64'(acc_cyc[2] - acc_cyc[1]), 64'd8);
        chk("b2b_lowrdy_0", 64'(acc_low[1] - acc_low[0]), 64'd4);
        chk("b2b_lowrdy_1", 64'(acc_low[2] - acc_low[1]), 64'd4);

        chk("scoreboard_empty", 64'(sbq.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
